// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_RESP   = 2'b10
    } arb_state_e;

    // Which requester currently owns the memory port
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int STARVE_LIM_DEF  = 4;

    // Widths of the timeout counter and the fetch-starvation counter
    localparam int TMO_W    = 8;
    localparam int STARVE_W = 4;

    // Saturating increment for the starvation counter
    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
        return (cnt == {STARVE_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Access timeout counter: counts wait cycles of one memory access and flags
// the terminal count at TIMEOUT_CYC-1. Shared with the bus bridge.
module arb_timeout_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    // Clear wins over enable; the count parks at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// The winning request is latched, driven on the memory bus until mem_ack or
// timeout, and answered with a one-cycle ack to the owner.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ARB_IDLE   | no transfer; arbitrate i_req/d_req, latch the winner's fields
// ARB_ACCESS | mem_req held with latched fields until mem_ack or timeout
// ARB_RESP   | one-cycle ack (and err) to the owner; requests are ignored
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int STARVE_LIM  = STARVE_LIM_DEF
) (
    input  logic                CLK,
    input  logic                RES,
    // fetch requester
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    // load/store requester
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    // memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [STARVE_W-1:0] STARVE_LIM_C = STARVE_W'(STARVE_LIM);

    arb_state_e          state_q,      state_d;
    arb_owner_e          owner_q,      owner_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                mem_req_q,    mem_req_d;
    logic                mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q,  mem_wstrb_d;
    logic                err_q,        err_d;
    logic [DATA_W-1:0]   i_rdata_q,    i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;

    logic grant_data;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_tc;

    arb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk_i (CLK),
        .rst_i (RES),
        .clr_i (tmo_clr),
        .en_i  (tmo_en),
        .tc_o  (tmo_tc)
    );

    // Arbitration, request latching, completion/timeout and response sequencing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        err_d        = err_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant_data   = 1'b0;
        tmo_clr      = 1'b0;
        tmo_en       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    // Data normally wins a tie; a fetch that has watched
                    // STARVE_LIM data grants in a row takes the port instead.
                    grant_data = d_req && !(i_req && (starve_cnt_q >= STARVE_LIM_C));
                    if (grant_data) begin
                        owner_d      = OWN_DATA;
                        mem_we_d     = d_we;
                        mem_addr_d   = d_addr;
                        mem_wdata_d  = d_wdata;
                        mem_wstrb_d  = d_wstrb;
                        starve_cnt_d = i_req ? starve_inc(starve_cnt_q) : '0;
                    end else begin
                        owner_d      = OWN_FETCH;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = i_addr;
                        mem_wdata_d  = '0;
                        mem_wstrb_d  = '0;
                        starve_cnt_d = '0;
                    end
                    mem_req_d = 1'b1;
                    err_d     = 1'b0;
                    tmo_clr   = 1'b1;
                    state_d   = ARB_ACCESS;
                end
            end

            ARB_ACCESS: begin
                if (mem_ack) begin
                    // A late ack in the terminal cycle still counts as success.
                    mem_req_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ARB_RESP;
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                end else if (tmo_tc) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ARB_RESP;
                    if (owner_q == OWN_DATA) begin
                        d_rdata_d = '0;
                    end else begin
                        i_rdata_d = '0;
                    end
                end else begin
                    tmo_en = 1'b1;
                end
            end

            ARB_RESP: begin
                err_d   = 1'b0;
                state_d = ARB_IDLE;
            end

            default: begin
                mem_req_d = 1'b0;
                err_d     = 1'b0;
                state_d   = ARB_IDLE;
            end
        endcase
    end

    // State, latched bus fields and response data registers.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_FETCH;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            err_q        <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    assign i_ack   = (state_q == ARB_RESP) && (owner_q == OWN_FETCH);
    assign d_ack   = (state_q == ARB_RESP) && (owner_q == OWN_DATA);
    assign i_err   = i_ack && err_q;
    assign d_err   = d_ack && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int TMO = 8;
    localparam int LIM = 4;

    logic        CLK = 1'b0;
    logic        RES;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int passed = 0;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TMO),
        .STARVE_LIM  (LIM)
    ) dut (
        .CLK       (CLK),
        .RES       (RES),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RES = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        mem_ack = 0; mem_rdata = 0;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, i_ack, d_ack, i_err, d_err, busy} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000", {mem_req, mem_we, i_ack, d_ack, i_err, d_err, busy});
        else passed++;
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0)
            $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%h want 0", mem_addr, mem_wdata, mem_wstrb);
        else passed++;
        checks++;
        if ({i_rdata, d_rdata} !== 64'h0)
            $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata);
        else passed++;
        RES = 1'b0;
        tick();
        checks++;
        if ({busy, mem_req} !== 2'b00)
            $display("FAIL idle_after_reset: got busy/mem_req=%b want 00", {busy, mem_req});
        else passed++;
    endtask

    task automatic test_single_fetch();
        i_req = 1; i_addr = 32'h100;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_wstrb, busy, i_ack} !== 8'b1_0_0000_1_0 || mem_addr !== 32'h100)
            $display("FAIL fetch_bus: got req/we/strb/busy/ack=%b addr=%h want 10000010 addr=00000100",
                     {mem_req, mem_we, mem_wstrb, busy, i_ack}, mem_addr);
        else passed++;
        mem_ack = 1; mem_rdata = 32'h0000_0013;
        tick();
        checks++;
        if ({i_ack, i_err, d_ack, mem_req} !== 4'b1000 || i_rdata !== 32'h13)
            $display("FAIL fetch_resp: got ack/err/dack/req=%b rdata=%h want 1000 rdata=00000013",
                     {i_ack, i_err, d_ack, mem_req}, i_rdata);
        else passed++;
        i_req = 0; mem_ack = 0; mem_rdata = 0;
        tick();
        checks++;
        if ({i_ack, busy} !== 2'b00)
            $display("FAIL fetch_idle: got ack/busy=%b want 00", {i_ack, busy});
        else passed++;
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({mem_req, mem_we, mem_wstrb, d_ack} !== 7'b1_1_1111_0 || mem_addr !== 32'h2004 || mem_wdata !== 32'hDEADBEEF)
                $display("FAIL store_hold_%0d: got req/we/strb/ack=%b addr=%h wdata=%h want 1111110 2004 deadbeef",
                         k, {mem_req, mem_we, mem_wstrb, d_ack}, mem_addr, mem_wdata);
            else passed++;
            if (k == 3) mem_ack = 1;
            tick();
        end
        checks++;
        if ({d_ack, d_err, i_ack, mem_req} !== 4'b1000)
            $display("FAIL store_resp: got dack/derr/iack/req=%b want 1000", {d_ack, d_err, i_ack, mem_req});
        else passed++;
        d_req = 0; d_we = 0; mem_ack = 0;
        tick();
        checks++;
        if ({d_ack, busy} !== 2'b00)
            $display("FAIL store_idle: got dack/busy=%b want 00", {d_ack, busy});
        else passed++;
    endtask

    task automatic test_simultaneous();
        i_req = 1; i_addr = 32'h1000;
        d_req = 1; d_we = 0; d_addr = 32'h2000;
        tick();
        checks++;
        if (mem_addr !== 32'h2000 || mem_we !== 1'b0 || mem_req !== 1'b1)
            $display("FAIL simul_data_first: got addr=%h we=%b req=%b want 00002000 0 1", mem_addr, mem_we, mem_req);
        else passed++;
        mem_ack = 1; mem_rdata = 32'hA5A5_0001;
        tick();
        checks++;
        if ({d_ack, i_ack} !== 2'b10 || d_rdata !== 32'hA5A50001)
            $display("FAIL simul_data_ack: got dack/iack=%b rdata=%h want 10 a5a50001", {d_ack, i_ack}, d_rdata);
        else passed++;
        d_req = 0; mem_ack = 0;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1000)
            $display("FAIL simul_fetch_next: got req=%b addr=%h want 1 00001000", mem_req, mem_addr);
        else passed++;
        mem_ack = 1; mem_rdata = 32'h0F0F_0F0F;
        tick();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h0F0F0F0F || d_rdata !== 32'hA5A50001)
            $display("FAIL simul_fetch_ack: got iack=%b irdata=%h drdata=%h want 1 0f0f0f0f a5a50001", i_ack, i_rdata, d_rdata);
        else passed++;
        i_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] got_addr[$];
        logic        prev_req;
        logic [31:0] exp_addr;
        int          n_d;
        int          n_f;
        prev_req = 1'b0;
        i_req = 1; i_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 32'hCAFE_0000; d_wstrb = 4'hF;
        for (int c = 0; c < 200 && got_addr.size() < 10; c++) begin
            tick();
            if (mem_req && !prev_req) got_addr.push_back(mem_addr);
            prev_req = mem_req;
            if (d_ack) begin
                d_addr  = d_addr + 32'd4;
                d_wdata = d_wdata + 32'd1;
            end
            if (i_ack) i_addr = i_addr + 32'd4;
            mem_ack = mem_req;
        end
        tick();
        i_req = 0; d_req = 0; mem_ack = 0;
        tick();
        tick();
        checks++;
        if (got_addr.size() != 10)
            $display("FAIL starve_grant_count: got %0d grants want 10", got_addr.size());
        else passed++;
        n_d = 0;
        n_f = 0;
        for (int g = 0; g < 10; g++) begin
            if (g % (LIM + 1) == LIM) begin
                exp_addr = 32'h300 + 32'(4 * n_f);
                n_f++;
            end else begin
                exp_addr = 32'h4000 + 32'(4 * n_d);
                n_d++;
            end
            if (g < got_addr.size()) begin
                checks++;
                if (got_addr[g] !== exp_addr)
                    $display("FAIL starve_grant_%0d: got addr=%h want %h", g, got_addr[g], exp_addr);
                else passed++;
            end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        bit seen;
        cnt = 0;
        seen = 0;
        d_req = 1; d_we = 0; d_addr = 32'h500; mem_ack = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick();
            if (d_ack) seen = 1;
            else if (mem_req) cnt++;
        end
        checks++;
        if (!seen) $display("FAIL timeout_no_ack: got no d_ack within 30 cycles want d_ack");
        else passed++;
        checks++;
        if (cnt != TMO) $display("FAIL timeout_req_len: got %0d cycles want %0d", cnt, TMO);
        else passed++;
        checks++;
        if ({d_err, i_ack} !== 2'b10 || d_rdata !== 32'h0)
            $display("FAIL timeout_resp: got derr/iack=%b rdata=%h want 10 00000000", {d_err, i_ack}, d_rdata);
        else passed++;
        d_addr = 32'h504;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h504)
            $display("FAIL timeout_next_grant: got req=%b addr=%h want 1 00000504", mem_req, mem_addr);
        else passed++;
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        checks++;
        if ({d_ack, d_err} !== 2'b10 || d_rdata !== 32'h12345678)
            $display("FAIL timeout_next_resp: got dack/derr=%b rdata=%h want 10 12345678", {d_ack, d_err}, d_rdata);
        else passed++;
        d_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        i_req = 1; i_addr = 32'h600;
        tick();
        tick();
        RES = 1;
        tick();
        checks++;
        if ({busy, mem_req, i_ack, d_ack} !== 4'b0000)
            $display("FAIL midrst_abort: got busy/req/iack/dack=%b want 0000", {busy, mem_req, i_ack, d_ack});
        else passed++;
        RES = 0; i_req = 0; mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({busy, mem_req, i_ack, d_ack, i_err, d_err} !== 6'b0 || i_rdata !== 32'h0)
                $display("FAIL midrst_late_ack_%0d: got ctrl=%b irdata=%h want 000000 00000000",
                         k, {busy, mem_req, i_ack, d_ack, i_err, d_err}, i_rdata);
            else passed++;
        end
        mem_ack = 0;
        tick();
    endtask

    task automatic test_random();
        int          phase;
        int          acc;
        int          lat;
        int          starve;
        int          i_gap;
        int          d_gap;
        bit          own_d;
        bit          no_ack;
        bit          e_err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rdata_i;
        logic [31:0] e_rdata_d;
        logic        s_i;
        logic        s_d;
        logic        s_ack;
        logic        s_dwe;
        logic [31:0] s_rdata;
        logic [31:0] s_iaddr;
        logic [31:0] s_daddr;
        logic [31:0] s_dwdata;
        logic [3:0]  s_dwstrb;
        phase = 0; acc = 0; lat = 0; starve = 0;
        own_d = 0; no_ack = 0; e_err = 0;
        e_addr = 0; e_wdata = 0; e_we = 0; e_wstrb = 0;
        e_rdata_i = 0; e_rdata_d = 0;
        i_gap = $urandom_range(0, 3);
        d_gap = $urandom_range(0, 3);
        i_req = 0; d_req = 0; mem_ack = 0;
        for (int c = 0; c < 600; c++) begin
            s_i = i_req; s_d = d_req; s_ack = mem_ack; s_rdata = mem_rdata;
            s_iaddr = i_addr; s_daddr = d_addr; s_dwe = d_we; s_dwdata = d_wdata; s_dwstrb = d_wstrb;
            tick();

            case (phase)
                0: if (s_i || s_d) begin
                    own_d = s_d && !(s_i && starve >= LIM);
                    if (own_d) begin
                        e_addr = s_daddr; e_we = s_dwe; e_wdata = s_dwdata; e_wstrb = s_dwstrb;
                        starve = s_i ? ((starve < 15) ? starve + 1 : 15) : 0;
                    end else begin
                        e_addr = s_iaddr; e_we = 1'b0; e_wdata = 32'h0; e_wstrb = 4'h0;
                        starve = 0;
                    end
                    phase = 1;
                    acc = 0;
                    no_ack = ($urandom_range(0, 5) == 0);
                    lat = ($urandom_range(0, 6) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
                end
                1: if (s_ack) begin
                    phase = 2;
                    e_err = 1'b0;
                    if (own_d) e_rdata_d = s_rdata;
                    else e_rdata_i = s_rdata;
                end else if (acc == TMO - 1) begin
                    phase = 2;
                    e_err = 1'b1;
                    if (own_d) e_rdata_d = 32'h0;
                    else e_rdata_i = 32'h0;
                end else begin
                    acc++;
                end
                default: phase = 0;
            endcase

            checks++;
            if ({mem_req, busy} !== {phase == 1, phase != 0})
                $display("FAIL rnd_req_busy c=%0d: got %b want %b", c, {mem_req, busy}, {phase == 1, phase != 0});
            else passed++;
            if (phase == 1) begin
                checks++;
                if (mem_addr !== e_addr || mem_we !== e_we || mem_wstrb !== e_wstrb || (own_d && mem_wdata !== e_wdata))
                    $display("FAIL rnd_bus c=%0d: got addr=%h we=%b strb=%h wdata=%h want %h %b %h %h",
                             c, mem_addr, mem_we, mem_wstrb, mem_wdata, e_addr, e_we, e_wstrb, e_wdata);
                else passed++;
            end
            checks++;
            if ({i_ack, d_ack, i_err, d_err} !== {phase == 2 && !own_d, phase == 2 && own_d,
                                                   phase == 2 && !own_d && e_err, phase == 2 && own_d && e_err})
                $display("FAIL rnd_ack_err c=%0d: got iack/dack/ierr/derr=%b want %b", c, {i_ack, d_ack, i_err, d_err},
                         {phase == 2 && !own_d, phase == 2 && own_d, phase == 2 && !own_d && e_err, phase == 2 && own_d && e_err});
            else passed++;
            checks++;
            if (i_rdata !== e_rdata_i || d_rdata !== e_rdata_d)
                $display("FAIL rnd_rdata c=%0d: got i=%h d=%h want i=%h d=%h", c, i_rdata, d_rdata, e_rdata_i, e_rdata_d);
            else passed++;

            if (phase == 2 && !own_d) begin
                if ($urandom_range(0, 2) == 0) i_addr = $urandom & 32'hFFFF_FFFC;
                else begin i_req = 1'b0; i_gap = $urandom_range(0, 3); end
            end else if (!i_req) begin
                if (i_gap == 0) begin i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC; end
                else i_gap--;
            end
            if (phase == 2 && own_d) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
                    d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
                end else begin d_req = 1'b0; d_gap = $urandom_range(0, 3); end
            end else if (!d_req) begin
                if (d_gap == 0) begin
                    d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1));
                    d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
                end else d_gap--;
            end
            // The owner scribbling on its fields mid-access must not reach the bus.
            if (phase == 1 && $urandom_range(0, 3) == 0) begin
                if (own_d) begin d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; end
                else i_addr = $urandom;
            end

            if (phase == 1) mem_ack = !no_ack && (acc == lat);
            else mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
        i_req = 0; d_req = 0; mem_ack = 0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    initial begin
        RES = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        mem_ack = 0; mem_rdata = 0;
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
